// File: rtl/mips_alu.sv
`default_nettype none
// ============================================================================
// Module      : bit_adder
// Description : Single-bit full adder. It is the cell of the ALU ripple chain
//               and is also instantiated on its own as the branch-target adder.
// Ports       : A, B   - addend bits
//               cin    - carry in
//               F      - sum bit
//               cout   - carry out
// Revision    : 1.0 - initial release
// ============================================================================
module bit_adder (
    input  logic A,
    input  logic B,
    input  logic cin,
    output logic F,
    output logic cout
);

    assign F    = A ^ B ^ cin;
    assign cout = (A & B) | (A & cin) | (B & cin);

endmodule

// ============================================================================
// Module      : mips_alu
// Description : 32-bit integer ALU for the EX stage of the 5-stage MIPS
//               pipeline. ADD/SUB/SLT share one ripple chain of bit_adder
//               cells. The combinational result feeds the EX/MEM register, and
//               a registered copy of result and carry is kept for status.
// Ports       : clk      - clock, rising edge updates result_q/cout_q
//               rst      - synchronous active-high reset of the status regs
//               A, B     - operands after the forwarding muxes
//               alucon   - operation select
//                          000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                          101 NOR, 110 SLT, 111 PASS
//               cin      - carry-in for ADD (tied to 0 in the pipeline)
//               ALU_out  - combinational result
//               cout     - combinational carry out of the top bit
//               result_q - ALU_out registered
//               cout_q   - cout registered
// Revision    : 1.0 - initial release
// ============================================================================
module mips_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       alucon,
    input  logic             cin,
    output logic [WIDTH-1:0] ALU_out,
    output logic             cout,
    output logic [WIDTH-1:0] result_q,
    output logic             cout_q
);

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_AND  = 3'b010;
    localparam logic [2:0] c_OP_OR   = 3'b011;
    localparam logic [2:0] c_OP_XOR  = 3'b100;
    localparam logic [2:0] c_OP_NOR  = 3'b101;
    localparam logic [2:0] c_OP_SLT  = 3'b110;
    localparam logic [2:0] c_OP_PASS = 3'b111;

    logic             w_sub;
    logic [WIDTH-1:0] w_b_chain;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic             w_slt;
    logic [WIDTH-1:0] w_alu_out;
    logic             w_cout;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;

    // SLT reuses the subtract path: A + ~B + 1.
    assign w_sub      = (alucon == c_OP_SUB) || (alucon == c_OP_SLT);
    assign w_b_chain  = w_sub ? ~B : B;
    assign w_carry[0] = w_sub ? 1'b1 : cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_chain
            bit_adder u_bit (
                .A    (A[i]),
                .B    (w_b_chain[i]),
                .cin  (w_carry[i]),
                .F    (w_sum[i]),
                .cout (w_carry[i+1])
            );
        end
    endgenerate

    // Signed overflow of A - B: operand signs differ and the result sign
    // disagrees with A. The true sign of the difference is sum sign ^ ovf.
    assign w_ovf = (A[WIDTH-1] ^ B[WIDTH-1]) & (w_sum[WIDTH-1] ^ A[WIDTH-1]);
    assign w_slt = w_sum[WIDTH-1] ^ w_ovf;

    always_comb begin
        w_alu_out = '0;
        w_cout    = 1'b0;
        case (alucon)
            c_OP_ADD: begin
                w_alu_out = w_sum;
                w_cout    = w_carry[WIDTH];
            end
            c_OP_SUB: begin
                w_alu_out = w_sum;
                w_cout    = w_carry[WIDTH];
            end
            c_OP_AND:  w_alu_out = A & B;
            c_OP_OR:   w_alu_out = A | B;
            c_OP_XOR:  w_alu_out = A ^ B;
            c_OP_NOR:  w_alu_out = ~(A | B);
            c_OP_SLT: begin
                w_alu_out = {{(WIDTH-1){1'b0}}, w_slt};
                w_cout    = w_carry[WIDTH];
            end
            c_OP_PASS: w_alu_out = A;
            // Unknown select must not masquerade as a legal result.
            default: begin
                w_alu_out = 'x;
                w_cout    = 1'bx;
            end
        endcase
    end

    assign ALU_out = w_alu_out;
    assign cout    = w_cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            r_result <= w_alu_out;
            r_cout   <= w_cout;
        end
    end

    assign result_q = r_result;
    assign cout_q   = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_mips_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_alu
// Description : Self-checking bench for mips_alu. Hand-computed directed
//               vectors pin the reference model; randomized operands, ops,
//               carry-in and occasional resets are then checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_alu;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  alucon;
    logic        cin;
    logic [31:0] ALU_out;
    logic        cout;
    logic [31:0] result_q;
    logic        cout_q;

    int n_tests;
    int n_fail;

    logic        r_started;
    logic [31:0] r_exp_rq;
    logic        r_exp_cq;

    mips_alu #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .alucon   (alucon),
        .cin      (cin),
        .ALU_out  (ALU_out),
        .cout     (cout),
        .result_q (result_q),
        .cout_q   (cout_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: returns {carry, result} from plain arithmetic.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic c);
        logic [32:0] s;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b} + {32'd0, c};
                return s;
            end
            3'd1: return {(a >= b), a - b};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, ~(a | b)};
            3'd6: return {(a >= b), (($signed(a) < $signed(b)) ? 32'd1 : 32'd0)};
            default: return {1'b0, a};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected status registers follow the model at each rising edge.
    always @(posedge clk) begin
        r_started <= 1'b1;
        if (rst)
            {r_exp_cq, r_exp_rq} <= 33'd0;
        else
            {r_exp_cq, r_exp_rq} <= model(A, B, alucon, cin);
    end

    // Compare process: every falling edge once the registers are defined.
    always @(negedge clk) begin
        logic [32:0] e;
        if (r_started === 1'b1) begin
            e = model(A, B, alucon, cin);
            chk("cyc_alu_out", ALU_out, e[31:0]);
            chk("cyc_cout", {31'd0, cout}, {31'd0, e[32]});
            chk("cyc_result_q", result_q, r_exp_rq);
            chk("cyc_cout_q", {31'd0, cout_q}, {31'd0, r_exp_cq});
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic c);
        @(posedge clk);
        #1;
        A = a; B = b; alucon = op; cin = c;
        #2;
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'h7FFF_FFFF;
            4: v = 32'h0000_0001;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        r_started = 1'b0;
        rst = 1'b1; A = '0; B = '0; alucon = 3'd0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result_q", result_q, 32'd0);
        chk("reset_cout_q", {31'd0, cout_q}, 32'd0);
        rst = 1'b0;

        // Directed vectors with literal expectations.
        drive(32'd5, 32'd3, 3'b000, 1'b0);
        chk("add_5_3", ALU_out, 32'd8);
        chk("add_5_3_cout", {31'd0, cout}, 32'd0);
        @(posedge clk); #1;
        chk("add_5_3_reg", result_q, 32'd8);

        drive(32'hFFFF_FFFF, 32'd1, 3'b000, 1'b0);
        chk("add_wrap", ALU_out, 32'd0);
        chk("add_wrap_cout", {31'd0, cout}, 32'd1);
        drive(32'd1, 32'd1, 3'b000, 1'b1);
        chk("add_cin", ALU_out, 32'd3);

        drive(32'd5, 32'd3, 3'b001, 1'b0);
        chk("sub_5_3", ALU_out, 32'd2);
        chk("sub_5_3_cout", {31'd0, cout}, 32'd1);
        drive(32'd3, 32'd5, 3'b001, 1'b1);
        chk("sub_3_5", ALU_out, 32'hFFFF_FFFE);
        chk("sub_3_5_cout", {31'd0, cout}, 32'd0);

        drive(32'h0000_F0F0, 32'h0000_FF00, 3'b010, 1'b0);
        chk("and", ALU_out, 32'h0000_F000);
        chk("and_cout", {31'd0, cout}, 32'd0);
        drive(32'h0000_F0F0, 32'h0000_FF00, 3'b011, 1'b0);
        chk("or", ALU_out, 32'h0000_FFF0);
        chk("or_cout", {31'd0, cout}, 32'd0);
        drive(32'h0000_F0F0, 32'h0000_FF00, 3'b100, 1'b0);
        chk("xor", ALU_out, 32'h0000_0FF0);
        chk("xor_cout", {31'd0, cout}, 32'd0);
        drive(32'h0000_F0F0, 32'h0000_FF00, 3'b101, 1'b0);
        chk("nor", ALU_out, 32'hFFFF_000F);
        chk("nor_cout", {31'd0, cout}, 32'd0);

        drive(32'hFFFF_FFFF, 32'd1, 3'b110, 1'b0);
        chk("slt_m1_1", ALU_out, 32'd1);
        drive(32'd1, 32'hFFFF_FFFF, 3'b110, 1'b0);
        chk("slt_1_m1", ALU_out, 32'd0);
        drive(32'h8000_0000, 32'h7FFF_FFFF, 3'b110, 1'b0);
        chk("slt_ovf", ALU_out, 32'd1);
        drive(32'h1234_5678, 32'hDEAD_BEEF, 3'b111, 1'b0);
        chk("pass", ALU_out, 32'h1234_5678);
        chk("pass_cout", {31'd0, cout}, 32'd0);

        // Reset only clears the registers; the combinational path stays live.
        drive(32'd5, 32'd3, 3'b000, 1'b0);
        @(posedge clk); #1;
        chk("rst_pre_reg", result_q, 32'd8);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_reg", result_q, 32'd0);
        chk("rst_cout_q", {31'd0, cout_q}, 32'd0);
        chk("rst_comb", ALU_out, 32'd8);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_reg", result_q, 32'd8);

        // Randomized phase; the negedge process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            A      = pick_operand();
            B      = pick_operand();
            alucon = 3'($urandom_range(0, 7));
            cin    = 1'($urandom_range(0, 1));
            rst    = ($urandom_range(0, 31) == 0);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
